// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes datapath enables and mux selects from the current state.
module mc_ctrl_fsm #(
  parameter int unsigned ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pcen,
  output logic [1:0]      pcsrc,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regdst,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            link,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      aluop,
  output logic            signext,
  output logic            shiftl16,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_ILLEGAL = 4'd13,
    S_UNUSED0 = 4'd14,
    S_UNUSED1 = 4'd15
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                       state_d = S_MEMADR;
          OP_RTYPE:                           state_d = (funct == FN_JR) ? S_JR : S_RTYPEEX;
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI:  state_d = S_IMMEX;
          OP_J, OP_JAL:                       state_d = S_JUMP;
          default:                            state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_ALUWB;
      S_IMMEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcen = 1'b0; pcsrc = '0; iord = 1'b0; memread = 1'b0; memwrite = 1'b0;
    irwrite = 1'b0; regdst = 1'b0; memtoreg = 1'b0; regwrite = 1'b0; link = 1'b0;
    alusrca = 1'b0; alusrcb = '0; aluop = '0; signext = 1'b0; shiftl16 = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        signext = 1'b1;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        signext = 1'b1;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b11;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = (op == OP_BNE) ? ~zero : zero;
      end
      S_IMMEX, S_IMMWB: begin
        // ALU controls are held into writeback so the result stays stable
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        regwrite = (state_q == S_IMMWB);
        case (op)
          OP_ORI:  aluop    = 2'b10;
          OP_LUI:  shiftl16 = 1'b1;
          default: signext  = 1'b1;
        endcase
      end
      S_JUMP: begin
        pcsrc    = 2'b10;
        pcen     = 1'b1;
        regwrite = (op == OP_JAL);
        link     = (op == OP_JAL);
      end
      S_JR: begin
        pcsrc = 2'b11;
        pcen  = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pcen = 1'b0; irwrite = 1'b0; regwrite = 1'b0; memread = 1'b0;
      memwrite = 1'b0; link = 1'b0; illegal = 1'b0;
    end
  end

  assign state = ST_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed per-cycle stimulus pushes the
// hand-computed expected state and output vector; a negedge monitor compares.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg;
  logic       regwrite, link, alusrca, signext, shiftl16, illegal;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic [3:0] state;

  mc_ctrl_fsm #(.ST_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .pcsrc(pcsrc), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .link(link),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .signext(signext),
    .shiftl16(shiftl16), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [18:0] PCEN   = 19'd1 << 18;
  localparam logic [18:0] PCS_BR = 19'd1 << 16;
  localparam logic [18:0] PCS_J  = 19'd2 << 16;
  localparam logic [18:0] PCS_RS = 19'd3 << 16;
  localparam logic [18:0] IORD   = 19'd1 << 15;
  localparam logic [18:0] MRD    = 19'd1 << 14;
  localparam logic [18:0] MWR    = 19'd1 << 13;
  localparam logic [18:0] IRW    = 19'd1 << 12;
  localparam logic [18:0] RDST   = 19'd1 << 11;
  localparam logic [18:0] M2R    = 19'd1 << 10;
  localparam logic [18:0] RW     = 19'd1 << 9;
  localparam logic [18:0] LINK   = 19'd1 << 8;
  localparam logic [18:0] ASA    = 19'd1 << 7;
  localparam logic [18:0] B4     = 19'd1 << 5;
  localparam logic [18:0] BIMM   = 19'd2 << 5;
  localparam logic [18:0] BSH    = 19'd3 << 5;
  localparam logic [18:0] OP_SUB = 19'd1 << 3;
  localparam logic [18:0] OP_OR  = 19'd2 << 3;
  localparam logic [18:0] OP_FN  = 19'd3 << 3;
  localparam logic [18:0] SX     = 19'd1 << 2;
  localparam logic [18:0] SH16   = 19'd1 << 1;
  localparam logic [18:0] ILL    = 19'd1;

  localparam logic [18:0] F_GO   = MRD | B4 | IRW | PCEN;
  localparam logic [18:0] F_WAIT = MRD | B4;
  localparam logic [18:0] DEC    = BSH | SX;
  localparam logic [18:0] MADR   = ASA | BIMM | SX;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
  localparam logic [5:0] JAL = 6'b000011, ADDI = 6'b001000, ADDIU = 6'b001001;
  localparam logic [5:0] ORI = 6'b001101, LUI = 6'b001111, BAD = 6'b111111;
  localparam logic [5:0] FADD = 6'b100000, FJR = 6'b001000;

  typedef struct {
    int         id;
    logic [3:0] st;
    logic [18:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   step_no = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  wire [18:0] got = {pcen, pcsrc, iord, memread, memwrite, irwrite, regdst,
                     memtoreg, regwrite, link, alusrca, alusrcb, aluop,
                     signext, shiftl16, illegal};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL step%0d state: got %0d want %0d", e.id, state, e.st);
      end
      n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL step%0d outputs: got %05h want %05h (state %0d)",
                 e.id, got, e.v, state);
      end
    end
  end

  task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic mr, input logic chk,
                      input logic [3:0] es, input logic [18:0] ev);
    exp_t e;
    reset = rst; op = o; funct = f; zero = z; mem_ready = mr;
    if (chk) begin
      e.id = step_no; e.st = es; e.v = ev;
      exp_q.push_back(e);
    end
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic c(input logic [5:0] o, input logic [5:0] f, input logic z,
                   input logic mr, input logic [3:0] es, input logic [18:0] ev);
    step(1'b0, o, f, z, mr, 1'b1, es, ev);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step(1'b1, RT, FADD, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step(1'b1, RT, FADD, 1'b0, 1'b0, 1'b0, 4'd0, '0);

    // SW into MEMWR stall, then reset mid-write
    c(SW, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(SW, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(SW, FADD, 1'b0, 1'b1, 4'd2, MADR);
    c(SW, FADD, 1'b0, 1'b0, 4'd5, IORD | MWR);
    step(1'b1, SW, FADD, 1'b0, 1'b0, 1'b1, 4'd5, IORD);
    step(1'b1, SW, FADD, 1'b0, 1'b1, 1'b1, 4'd0, B4);

    // LW: two FETCH waits, one MEMRD wait
    c(LW, FADD, 1'b0, 1'b0, 4'd0, F_WAIT);
    c(LW, FADD, 1'b0, 1'b0, 4'd0, F_WAIT);
    c(LW, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(LW, FADD, 1'b0, 1'b0, 4'd1, DEC);
    c(LW, FADD, 1'b0, 1'b1, 4'd2, MADR);
    c(LW, FADD, 1'b0, 1'b0, 4'd3, IORD | MRD);
    c(LW, FADD, 1'b0, 1'b1, 4'd3, IORD | MRD);
    c(LW, FADD, 1'b0, 1'b1, 4'd4, M2R | RW);

    // SW with no stalls
    c(SW, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(SW, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(SW, FADD, 1'b0, 1'b1, 4'd2, MADR);
    c(SW, FADD, 1'b0, 1'b1, 4'd5, IORD | MWR);

    // R-type
    c(RT, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(RT, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(RT, FADD, 1'b0, 1'b1, 4'd6, ASA | OP_FN);
    c(RT, FADD, 1'b0, 1'b1, 4'd7, RDST | RW);

    // Branches, both zero polarities
    c(BEQ, FADD, 1'b1, 1'b1, 4'd0, F_GO);
    c(BEQ, FADD, 1'b1, 1'b1, 4'd1, DEC);
    c(BEQ, FADD, 1'b1, 1'b1, 4'd8, ASA | OP_SUB | PCS_BR | PCEN);
    c(BNE, FADD, 1'b1, 1'b1, 4'd0, F_GO);
    c(BNE, FADD, 1'b1, 1'b1, 4'd1, DEC);
    c(BNE, FADD, 1'b1, 1'b1, 4'd8, ASA | OP_SUB | PCS_BR);
    c(BEQ, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(BEQ, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(BEQ, FADD, 1'b0, 1'b1, 4'd8, ASA | OP_SUB | PCS_BR);
    c(BNE, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(BNE, FADD, 1'b0, 1'b0, 4'd1, DEC);
    c(BNE, FADD, 1'b0, 1'b1, 4'd8, ASA | OP_SUB | PCS_BR | PCEN);

    // Jumps
    c(JAL, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(JAL, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(JAL, FADD, 1'b0, 1'b1, 4'd11, PCS_J | PCEN | RW | LINK);
    c(J, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(J, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(J, FADD, 1'b0, 1'b1, 4'd11, PCS_J | PCEN);
    c(RT, FJR, 1'b0, 1'b1, 4'd0, F_GO);
    c(RT, FJR, 1'b0, 1'b1, 4'd1, DEC);
    c(RT, FJR, 1'b0, 1'b1, 4'd12, PCS_RS | PCEN);

    // Immediates
    c(ORI, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(ORI, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(ORI, FADD, 1'b0, 1'b1, 4'd9, ASA | BIMM | OP_OR);
    c(ORI, FADD, 1'b0, 1'b1, 4'd10, ASA | BIMM | OP_OR | RW);
    c(LUI, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(LUI, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(LUI, FADD, 1'b0, 1'b1, 4'd9, ASA | BIMM | SH16);
    c(LUI, FADD, 1'b0, 1'b1, 4'd10, ASA | BIMM | SH16 | RW);
    c(ADDI, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(ADDI, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(ADDI, FADD, 1'b0, 1'b1, 4'd9, ASA | BIMM | SX);
    c(ADDI, FADD, 1'b0, 1'b1, 4'd10, ASA | BIMM | SX | RW);
    c(ADDIU, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(ADDIU, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(ADDIU, FADD, 1'b0, 1'b1, 4'd9, ASA | BIMM | SX);
    c(ADDIU, FADD, 1'b0, 1'b1, 4'd10, ASA | BIMM | SX | RW);

    // Illegal opcode
    c(BAD, FADD, 1'b0, 1'b1, 4'd0, F_GO);
    c(BAD, FADD, 1'b0, 1'b1, 4'd1, DEC);
    c(BAD, FADD, 1'b0, 1'b1, 4'd13, ILL);
    c(BAD, FADD, 1'b0, 1'b0, 4'd0, F_WAIT);

    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
